// File: rtl/run_harness.sv
// Run controller: clears data memory, loads LFSR messages, launches the core and times it to halt.
// All outputs registered, one state per cycle; no backpressure, go is honoured only when not busy.
module run_harness #(
  parameter int          MSG_W          = 11,
  parameter int          MSG_COUNT      = 15,
  parameter int          DATA_W         = 8,
  parameter int          ADDR_W         = 8,
  parameter int          BASE_ADDR      = 0,
  parameter int          CLEAR_DEPTH    = 256,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              go,
  input  logic              dut_halt,
  output logic              dut_start,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              msg_valid,
  output logic [MSG_W-1:0]  msg_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       cycle_count
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLEAR      = 3'd1;
  localparam logic [2:0] S_LOAD_LO    = 3'd2;
  localparam logic [2:0] S_LOAD_HI    = 3'd3;
  localparam logic [2:0] S_START_HOLD = 3'd4;
  localparam logic [2:0] S_RUN        = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;
  localparam logic [2:0] S_TIMEOUT    = 3'd7;

  localparam int                CNT_W      = ADDR_W + 1;
  localparam logic [15:0]       SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0]  CLEAR_LAST = CNT_W'(CLEAR_DEPTH - 1);
  localparam logic [CNT_W-1:0]  MSG_LAST   = CNT_W'(MSG_COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       TO_LIMIT   = 32'(TIMEOUT_CYCLES);

  if (!(MSG_W > DATA_W && MSG_W <= 2 * DATA_W && MSG_W <= 16)) begin : g_bad_msg_w
    $error("run_harness: MSG_W must satisfy DATA_W < MSG_W <= 2*DATA_W and fit the 16-bit LFSR");
  end
  if (BASE_ADDR + 2 * MSG_COUNT > 2 ** ADDR_W) begin : g_bad_base
    $error("run_harness: message block does not fit in the address space");
  end
  if (CLEAR_DEPTH > 2 ** ADDR_W) begin : g_bad_clear
    $error("run_harness: CLEAR_DEPTH exceeds the address space");
  end

  logic [2:0]        state, state_n;
  logic [15:0]       lfsr, lfsr_n, lfsr_adv;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              wr_n, mv_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic [MSG_W-1:0]  md_n;
  logic [31:0]       cc_n;

  assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    wr_n    = 1'b0;
    mv_n    = 1'b0;
    addr_n  = mem_addr;
    data_n  = mem_wr_data;
    md_n    = msg_data;
    cc_n    = cycle_count;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (go) begin
          cc_n  = 32'd0;
          cnt_n = '0;
          wr_n  = 1'b1;
          if (CLEAR_DEPTH == 0) begin
            state_n = S_LOAD_LO;
            addr_n  = BASE;
            data_n  = lfsr[DATA_W-1:0];
            mv_n    = 1'b1;
            md_n    = lfsr[MSG_W-1:0];
          end else begin
            state_n = S_CLEAR;
            addr_n  = '0;
            data_n  = '0;
          end
        end
      end
      S_CLEAR: begin
        wr_n = 1'b1;
        if (cnt == CLEAR_LAST) begin
          state_n = S_LOAD_LO;
          cnt_n   = '0;
          addr_n  = BASE;
          data_n  = lfsr[DATA_W-1:0];
          mv_n    = 1'b1;
          md_n    = lfsr[MSG_W-1:0];
        end else begin
          cnt_n  = cnt + CNT_W'(1);
          addr_n = cnt_n[ADDR_W-1:0];
          data_n = '0;
        end
      end
      S_LOAD_LO: begin
        state_n = S_LOAD_HI;
        wr_n    = 1'b1;
        addr_n  = mem_addr + ADDR_W'(1);
        data_n  = DATA_W'(lfsr[MSG_W-1:DATA_W]);
      end
      S_LOAD_HI: begin
        // The next message's low byte is built from the already-advanced LFSR.
        lfsr_n = lfsr_adv;
        if (cnt == MSG_LAST) begin
          state_n = S_START_HOLD;
        end else begin
          state_n = S_LOAD_LO;
          cnt_n   = cnt + CNT_W'(1);
          wr_n    = 1'b1;
          addr_n  = mem_addr + ADDR_W'(1);
          data_n  = lfsr_adv[DATA_W-1:0];
          mv_n    = 1'b1;
          md_n    = lfsr_adv[MSG_W-1:0];
        end
      end
      S_START_HOLD: state_n = S_RUN;
      S_RUN: begin
        if (dut_halt) begin
          state_n = S_DONE;
        end else begin
          cc_n = cycle_count + 32'd1;
          if (cc_n == TO_LIMIT) state_n = S_TIMEOUT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      lfsr        <= SEED_EFF;
      cnt         <= '0;
      dut_start   <= 1'b1;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      msg_valid   <= 1'b0;
      msg_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      state       <= state_n;
      lfsr        <= lfsr_n;
      cnt         <= cnt_n;
      dut_start   <= (state_n != S_RUN);
      mem_wr_en   <= wr_n;
      mem_addr    <= addr_n;
      mem_wr_data <= data_n;
      msg_valid   <= mv_n;
      msg_data    <= md_n;
      busy        <= (state_n == S_CLEAR) || (state_n == S_LOAD_LO) || (state_n == S_LOAD_HI) ||
                     (state_n == S_START_HOLD) || (state_n == S_RUN);
      done        <= (state_n == S_DONE);
      timed_out   <= (state_n == S_TIMEOUT);
      cycle_count <= cc_n;
    end
  end

endmodule

// File: tb/tb_run_harness.sv
// Directed bench for run_harness: scoreboard of expected memory writes and messages, short timeout build.
module tb_run_harness;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        go;
  logic        dut_halt;
  logic        dut_start;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic        msg_valid;
  logic [10:0] msg_data;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [31:0] cycle_count;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [10:0] mq[$];
  logic [15:0] mlfsr = 16'hACE1;
  logic [10:0] first_msg;
  logic        first_pending = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  run_harness #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .Reset(Reset), .go(go), .dut_halt(dut_halt), .dut_start(dut_start),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .msg_valid(msg_valid), .msg_data(msg_data), .busy(busy), .done(done),
    .timed_out(timed_out), .cycle_count(cycle_count)
  );

  function automatic logic [15:0] lnext(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge and retire any write or message against the queues.
  task automatic step();
    wr_t         e;
    logic [10:0] m;
    @(negedge CLK);
    if (mem_wr_en) begin
      chk("wr_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wr_data), 32'(e.d));
      end
    end
    if (msg_valid) begin
      chk("msg_expected", 32'(mq.size() > 0), 32'd1);
      if (mq.size() > 0) begin
        m = mq.pop_front();
        chk("msg_data", 32'(msg_data), 32'(m));
        if (first_pending) begin
          first_msg     = msg_data;
          first_pending = 1'b0;
        end
      end
    end
  endtask

  task automatic push_run();
    for (int a = 0; a < 256; a++) wq.push_back('{a: 8'(a), d: 8'h00});
    for (int i = 0; i < 15; i++) begin
      wq.push_back('{a: 8'(2 * i), d: mlfsr[7:0]});
      wq.push_back('{a: 8'(2 * i + 1), d: {5'b0, mlfsr[10:8]}});
      mq.push_back(mlfsr[10:0]);
      mlfsr = lnext(mlfsr);
    end
  endtask

  task automatic launch();
    push_run();
    first_pending = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    chk("launch_busy", 32'(busy), 32'd1);
    chk("launch_wr_en", 32'(mem_wr_en), 32'd1);
    chk("launch_done", 32'(done), 32'd0);
    chk("launch_timed_out", 32'(timed_out), 32'd0);
  endtask

  // Remaining 285 write cycles, START_HOLD, then stop at the first RUN cycle.
  task automatic run_load(input int go_at);
    for (int t = 1; t < 286; t++) begin
      go = (t == go_at);
      step();
      chk("load_start_high", 32'(dut_start), 32'd1);
    end
    go = 1'b0;
    chk("load_wr_left", 32'(wq.size()), 32'd0);
    chk("load_msg_left", 32'(mq.size()), 32'd0);
    step();
    chk("hold_start", 32'(dut_start), 32'd1);
    chk("hold_wr_en", 32'(mem_wr_en), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    step();
    chk("run_start_low", 32'(dut_start), 32'd0);
    chk("run_count0", cycle_count, 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_dut_start", 32'(dut_start), 32'd1);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_msg_valid", 32'(msg_valid), 32'd0);
    chk("rst_msg_data", 32'(msg_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    go       = 1'b0;
    dut_halt = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset();
    Reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Run 1: seeded messages, core halts after 5 RUN cycles.
    launch();
    run_load(-1);
    chk("run1_first_msg", 32'(first_msg), 32'h4E1);
    repeat (4) step();
    chk("run1_count_mid", cycle_count, 32'd4);
    chk("run1_busy", 32'(busy), 32'd1);
    step();
    dut_halt = 1'b1;
    step();
    chk("run1_done", 32'(done), 32'd1);
    chk("run1_busy_off", 32'(busy), 32'd0);
    chk("run1_count", cycle_count, 32'd5);
    chk("run1_start_high", 32'(dut_start), 32'd1);
    dut_halt = 1'b0;
    repeat (2) step();
    chk("run1_done_held", 32'(done), 32'd1);
    chk("run1_count_held", cycle_count, 32'd5);

    // Run 2: fresh messages, no halt -> timeout at 8 cycles.
    launch();
    run_load(-1);
    chk("run2_msg_new", 32'(first_msg != 11'h4E1), 32'd1);
    repeat (8) step();
    chk("run2_timed_out", 32'(timed_out), 32'd1);
    chk("run2_count", cycle_count, 32'd8);
    chk("run2_done", 32'(done), 32'd0);
    chk("run2_busy", 32'(busy), 32'd0);
    chk("run2_start_high", 32'(dut_start), 32'd1);
    repeat (3) step();
    chk("run2_count_sat", cycle_count, 32'd8);
    chk("run2_flag_held", 32'(timed_out), 32'd1);

    // Run 3: halt held through clear/load and a stray go mid-load; first RUN cycle halts.
    dut_halt = 1'b1;
    launch();
    chk("run3_count_clr", cycle_count, 32'd0);
    run_load(260);
    step();
    chk("run3_done", 32'(done), 32'd1);
    chk("run3_count", cycle_count, 32'd0);
    dut_halt = 1'b0;

    // Run 4: reset during LOAD_HI of message 2, then a clean run restarts from the seed.
    launch();
    repeat (261) step();
    chk("run4_in_load_hi", 32'(mem_addr), 32'd5);
    Reset = 1'b1;
    wq.delete();
    mq.delete();
    step();
    chk_reset();
    Reset = 1'b0;
    mlfsr = 16'hACE1;
    launch();
    run_load(-1);
    chk("run4_first_msg", 32'(first_msg), 32'h4E1);
    dut_halt = 1'b1;
    step();
    chk("run4_done", 32'(done), 32'd1);
    dut_halt = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
